switch_press_classifier: RTL and testbench
==========================================

Name: switch_press_classifier

Overview:
- Consumes the debounced switch level produced by the debounce filter, on the same clock domain.
- Classifies each user gesture as short press, long press or double click.
- Emits a single-cycle pulse per classified gesture to downstream logic (LED toggles, mode selects).
- Replaces raw edge-to-toggle logic wherever more than one action per button is needed.

Parameters:
- LONG_PRESS_LIMIT, 12500000: cycles the switch must stay high to be a long press (0.5 s at 25 MHz). Legal values are 2 or more.
- DOUBLE_CLICK_WINDOW, 6250000: cycles after a release during which a second press counts as a double click (250 ms). Legal values are 2 or more.

Ports:
- i_Clk  input  1  system clock, 25 MHz on board.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Switch  input  1  debounced switch level, 1 = pressed, synchronous to i_Clk.
- o_Short_Press  output  1  one-cycle pulse for a short press.
- o_Long_Press  output  1  one-cycle pulse for a long press.
- o_Double_Click  output  1  one-cycle pulse for a double click.
- o_Pressed  output  1  registered copy of i_Switch.
- o_Busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: asserted while i_Rst_L is low, asynchronously. State goes to IDLE, the counter to 0, and every output to 0. Reset mid-gesture discards that gesture with no pulse.
- Counter: single counter, width $clog2 of the larger limit. It clears on every state change. All decisions use the i_Switch level sampled at each rising edge of i_Clk.
- All outputs are registered. Pulses are exactly 1 cycle wide. At most one pulse fires per gesture.
- IDLE:
  - i_Switch=1 goes to PRESSED_1.
  - A switch held high through reset deassertion counts as a press starting at the first edge after deassertion.
- PRESSED_1:
  - i_Switch=0 goes to WAIT_SECOND.
  - Else, if count == LONG_PRESS_LIMIT-1: o_Long_Press=1 and go to HELD_LONG.
  - Else, count+1.
  - If the release and the limit fall on the same edge, the release wins and there is no long press.
- HELD_LONG:
  - i_Switch=0 goes to IDLE with no pulse. Otherwise hold.
- WAIT_SECOND:
  - i_Switch=1 goes to PRESSED_2.
  - Else, if count == DOUBLE_CLICK_WINDOW-1: o_Short_Press=1 and go to IDLE.
  - Else, count+1.
  - If the press and the window expiry fall on the same edge, the press wins.
- PRESSED_2:
  - i_Switch=0: o_Double_Click=1 and go to IDLE.
  - The length of the second press is not measured.
- Latency, with E0 as the edge entering PRESSED_1:
  - o_Long_Press is high in the cycle after edge E0+LONG_PRESS_LIMIT.
  - o_Short_Press is high DOUBLE_CLICK_WINDOW edges after the release edge.
  - o_Double_Click is high in the cycle after the second release edge.
- o_Pressed and o_Busy are updated every edge with 1-cycle latency.

Optional Feature:
- Macro: SWITCH_PRESS_DOUBLE_CLICK_EN.
- Defined: full behaviour as above.
- Undefined:
  - WAIT_SECOND and PRESSED_2 are not built, and o_Double_Click is tied to 0.
  - In PRESSED_1, i_Switch=0 gives o_Short_Press=1 on that edge and goes to IDLE, a 1-cycle latency from the release.
  - DOUBLE_CLICK_WINDOW is unused.

Test Plan (LONG_PRESS_LIMIT=20, DOUBLE_CLICK_WINDOW=10, macro defined unless stated):
- Reset: hold i_Rst_L=0 while toggling i_Switch -> all outputs 0. Press, then assert reset 5 cycles into PRESSED_1 -> no pulse, o_Busy drops to 0 immediately.
- Short press: press 5 cycles, release, stay low -> o_Short_Press pulses once, 10 cycles after the release edge; no other pulse; o_Busy returns to 0.
- Long press: hold 30 cycles -> o_Long_Press pulses in the cycle after edge E0+20; release -> no further pulse.
- Boundary: release on the edge where count = 19 -> no long press, short press later. Press again on the edge where the window count = 9 -> PRESSED_2, then o_Double_Click on release.
- Double click: press 5, low 4, press 5, release -> o_Double_Click pulses once, in the cycle after the second release; o_Short_Press stays 0.
- Macro undefined: press 5, release -> o_Short_Press in the cycle after the release edge. Then press 5, low 4, press 5 -> two short pulses, and o_Double_Click is never asserted.

Source files
------------

// File: rtl/switch_press_classifier.sv
// Classifies debounced switch gestures into short/long/double-click pulses.
// Double-click detection is built only when SWITCH_PRESS_DOUBLE_CLICK_EN is defined.
module switch_press_classifier #(
  parameter int LONG_PRESS_LIMIT    = 12500000,
  parameter int DOUBLE_CLICK_WINDOW = 6250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Short_Press,
  output logic o_Long_Press,
  output logic o_Double_Click,
  output logic o_Pressed,
  output logic o_Busy
);

  localparam int MAXL = (LONG_PRESS_LIMIT > DOUBLE_CLICK_WINDOW) ?
                        LONG_PRESS_LIMIT : DOUBLE_CLICK_WINDOW;
  localparam int CW = $clog2(MAXL);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_LIMIT - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED_1,
    HELD_LONG,
    WAIT_SECOND,
    PRESSED_2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          short_q;
  logic          long_q;
  logic          pressed_q;
  logic          busy_q;
`ifdef SWITCH_PRESS_DOUBLE_CLICK_EN
  localparam logic [CW-1:0] WIN_LAST = CW'(DOUBLE_CLICK_WINDOW - 1);
  logic          dbl_q;
`endif

  // busy_q tracks the state being entered so it always mirrors state_q
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      pressed_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SWITCH_PRESS_DOUBLE_CLICK_EN
      dbl_q     <= 1'b0;
`endif
    end else begin
      pressed_q <= i_Switch;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
`ifdef SWITCH_PRESS_DOUBLE_CLICK_EN
      dbl_q     <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (i_Switch) begin
            state_q <= PRESSED_1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        PRESSED_1: begin
          if (!i_Switch) begin
            cnt_q <= '0;
`ifdef SWITCH_PRESS_DOUBLE_CLICK_EN
            state_q <= WAIT_SECOND;
`else
            short_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end else if (cnt_q == LONG_LAST) begin
            long_q  <= 1'b1;
            state_q <= HELD_LONG;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        HELD_LONG: begin
          if (!i_Switch) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
`ifdef SWITCH_PRESS_DOUBLE_CLICK_EN
        WAIT_SECOND: begin
          if (i_Switch) begin
            state_q <= PRESSED_2;
            cnt_q   <= '0;
          end else if (cnt_q == WIN_LAST) begin
            short_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        PRESSED_2: begin
          if (!i_Switch) begin
            dbl_q   <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Short_Press = short_q;
  assign o_Long_Press  = long_q;
  assign o_Pressed     = pressed_q;
  assign o_Busy        = busy_q;
`ifdef SWITCH_PRESS_DOUBLE_CLICK_EN
  assign o_Double_Click = dbl_q;
`else
  assign o_Double_Click = 1'b0;
`endif

endmodule

// File: tb/tb_switch_press_classifier.sv
// Directed gesture table plus reset sequences for switch_press_classifier.
// Expectations follow SWITCH_PRESS_DOUBLE_CLICK_EN as compiled.
module tb_switch_press_classifier;

  localparam int LPL = 20;
  localparam int DCW = 10;
  localparam int NV  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sw    = 1'b0;
  logic sp, lp, dc, pr, bz;

  int errs   = 0;
  int checks = 0;

  switch_press_classifier #(
    .LONG_PRESS_LIMIT(LPL),
    .DOUBLE_CLICK_WINDOW(DCW)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .i_Switch(sw),
    .o_Short_Press(sp),
    .o_Long_Press(lp),
    .o_Double_Click(dc),
    .o_Pressed(pr),
    .o_Busy(bz)
  );

  always #5 clk = ~clk;

  // kinds: 0 none, 1 short, 2 long, 3 double; cN = step index after
  // whose edge the pulse is visible (step 0 is the first press edge)
  typedef struct {
    int p1;
    int g;
    int p2;
    int tail;
    int k0;
    int c0;
    int k1;
    int c1;
  } vec_t;

  vec_t tbl [NV];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step(input logic s);
    sw = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic hit(input vec_t v, input int kind, input int i);
    return (v.k0 == kind && v.c0 == i) || (v.k1 == kind && v.c1 == i);
  endfunction

  task automatic run_vec(input int n);
    int len;
    logic s;
    len = tbl[n].p1 + tbl[n].g + tbl[n].p2 + tbl[n].tail;
    for (int i = 0; i < len; i++) begin
      s = (i < tbl[n].p1) ||
          (tbl[n].p2 > 0 && i >= tbl[n].p1 + tbl[n].g &&
           i < tbl[n].p1 + tbl[n].g + tbl[n].p2);
      step(s);
      chk($sformatf("v%0d short c%0d", n, i), sp, hit(tbl[n], 1, i));
      chk($sformatf("v%0d long c%0d", n, i), lp, hit(tbl[n], 2, i));
      chk($sformatf("v%0d dbl c%0d", n, i), dc, hit(tbl[n], 3, i));
      chk($sformatf("v%0d pressed c%0d", n, i), pr, s);
      if (i == 0) chk($sformatf("v%0d busy start", n), bz, 1'b1);
    end
    chk($sformatf("v%0d busy end", n), bz, 1'b0);
  endtask

  initial begin
`ifdef SWITCH_PRESS_DOUBLE_CLICK_EN
    tbl[0] = '{5, 0, 0, 16, 1, 15, 0, 0};
    tbl[1] = '{30, 0, 0, 5, 2, 20, 0, 0};
    tbl[2] = '{20, 0, 0, 14, 1, 30, 0, 0};
    tbl[3] = '{5, 10, 5, 14, 3, 20, 0, 0};
    tbl[4] = '{5, 4, 5, 14, 3, 14, 0, 0};
`else
    tbl[0] = '{5, 0, 0, 16, 1, 5, 0, 0};
    tbl[1] = '{30, 0, 0, 5, 2, 20, 0, 0};
    tbl[2] = '{20, 0, 0, 14, 1, 20, 0, 0};
    tbl[3] = '{5, 10, 5, 14, 1, 5, 1, 20};
    tbl[4] = '{5, 4, 5, 14, 1, 5, 1, 14};
`endif

    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(i[0]);
      chk("rst short", sp, 1'b0);
      chk("rst long", lp, 1'b0);
      chk("rst dbl", dc, 1'b0);
      chk("rst pressed", pr, 1'b0);
      chk("rst busy", bz, 1'b0);
    end

    // switch held high across reset release starts a press
    sw    = 1'b1;
    rst_n = 1'b1;
    for (int n = 0; n < NV; n++) run_vec(n);

    for (int i = 0; i < 6; i++) step(1'b1);
    chk("mid busy before rst", bz, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst busy", bz, 1'b0);
    chk("mid rst pressed", pr, 1'b0);
    chk("mid rst short", sp, 1'b0);
    chk("mid rst long", lp, 1'b0);
    step(1'b1);
    step(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(1'b0);
      chk($sformatf("post rst short c%0d", i), sp, 1'b0);
      chk($sformatf("post rst long c%0d", i), lp, 1'b0);
      chk($sformatf("post rst dbl c%0d", i), dc, 1'b0);
      chk($sformatf("post rst busy c%0d", i), bz, 1'b0);
    end

    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
